// File: rtl/bz_note_sequencer_if.sv
// Melody ROM / beat decoder bus for the buzzer note sequencer.
// The sequencer (master) drives the ROM address and the beat code to the
// decoder; the ROM/decoder side (slave) returns the ROM word and the
// decoded note length in clk cycles.
interface bz_note_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_data;
  logic [3:0]        beat;
  logic [27:0]       beat_cnt_parameter;

  modport master (
    output rom_addr,
    output beat,
    input  rom_data,
    input  beat_cnt_parameter
  );

  modport slave (
    input  rom_addr,
    input  beat,
    output rom_data,
    output beat_cnt_parameter
  );
endinterface

// File: rtl/bz_note_sequencer.sv
// Melody playback sequencer for the buzzer path.
// Walks the melody ROM, hands each beat code to the beat decoder, times the
// note to the decoded cycle count and drives tone/tone_en to the PWM stage.
// Optional build macro BZ_SEQ_GAP_EN inserts a muted GAP_CYCLES gap after
// every note; without it the note-to-note overhead is FETCH+LOAD only.
module bz_note_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int GAP_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  bz_note_sequencer_if.master   bus,
  output logic [3:0]            tone,
  output logic                  tone_en,
  output logic                  busy,
  output logic                  song_done,
  output logic                  bad_beat
);

  // A zero-length gap would make the GAP state meaningless.
  if (GAP_CYCLES < 1) begin : g_gap_param_check
    $error("bz_note_sequencer: GAP_CYCLES must be at least 1");
  end

`ifdef BZ_SEQ_GAP_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_e;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [27:0]       cnt_q, cnt_d;
  logic [3:0]        tone_q, tone_d;
  logic              tone_en_q, tone_en_d;
  logic              busy_q, busy_d;
  logic              song_done_q, song_done_d;
  logic              bad_beat_q, bad_beat_d;

  logic              end_flag_s;
  logic [3:0]        rom_tone_s;

  assign end_flag_s   = bus.rom_data[8];
  assign rom_tone_s   = bus.rom_data[7:4];
  assign bus.beat     = bus.rom_data[3:0];
  assign bus.rom_addr = addr_q;

  assign tone      = tone_q;
  assign tone_en   = tone_en_q;
  assign busy      = busy_q;
  assign song_done = song_done_q;
  assign bad_beat  = bad_beat_q;

  // Next-state and next-output logic; stop overrides every other decision.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    tone_d      = tone_q;
    tone_en_d   = tone_en_q;
    song_done_d = 1'b0;
    bad_beat_d  = 1'b0;
`ifdef BZ_SEQ_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif
    if ((state_q != S_IDLE) && stop) begin
      state_d   = S_IDLE;
      addr_d    = {ADDR_W{1'b0}};
      cnt_d     = 28'd0;
      tone_d    = 4'd0;
      tone_en_d = 1'b0;
`ifdef BZ_SEQ_GAP_EN
      gap_cnt_d = {GAP_W{1'b0}};
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // start together with stop is treated as no start at all
          if (start && !stop) begin
            state_d = S_FETCH;
            addr_d  = {ADDR_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          // one cycle of synchronous ROM latency
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (end_flag_s) begin
            if (loop_en) begin
              addr_d  = {ADDR_W{1'b0}};
              state_d = S_FETCH;
            end else begin
              song_done_d = 1'b1;
              state_d     = S_IDLE;
            end
          end else if (bus.beat_cnt_parameter == 28'd0) begin
            bad_beat_d = 1'b1;
            addr_d     = addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end else begin
            cnt_d     = bus.beat_cnt_parameter - 28'd1;
            tone_d    = rom_tone_s;
            tone_en_d = (rom_tone_s != 4'd0);
            state_d   = S_PLAY;
          end
        end
        S_PLAY: begin
          if (cnt_q == 28'd0) begin
            tone_en_d = 1'b0;
            tone_d    = 4'd0;
`ifdef BZ_SEQ_GAP_EN
            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
            state_d   = S_GAP;
`else
            addr_d    = addr_q + ADDR_W'(1);
            state_d   = S_FETCH;
`endif
          end else begin
            cnt_d = cnt_q - 28'd1;
          end
        end
`ifdef BZ_SEQ_GAP_EN
        S_GAP: begin
          if (gap_cnt_q == {GAP_W{1'b0}}) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
`endif
        default: begin
          state_d   = S_IDLE;
          addr_d    = {ADDR_W{1'b0}};
          cnt_d     = 28'd0;
          tone_d    = 4'd0;
          tone_en_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; async reset silences the buzzer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      cnt_q       <= 28'd0;
      tone_q      <= 4'd0;
      tone_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      song_done_q <= 1'b0;
      bad_beat_q  <= 1'b0;
`ifdef BZ_SEQ_GAP_EN
      gap_cnt_q   <= {GAP_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      tone_q      <= tone_d;
      tone_en_q   <= tone_en_d;
      busy_q      <= busy_d;
      song_done_q <= song_done_d;
      bad_beat_q  <= bad_beat_d;
`ifdef BZ_SEQ_GAP_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

endmodule
